// File: rtl/io_mem_slave_if.sv
// Spike IO bus bundle between the transaction driver (master) and a target (slave).
// Optional macro IO_SLAVE_ERR_EN adds the io_data_err response flag.
interface io_mem_slave_if;
  logic        io_req;
  logic        io_wr;
  logic [3:0]  io_wen;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_req_ack;
  logic [31:0] io_rdata;
  logic        io_data_ack;
`ifdef IO_SLAVE_ERR_EN
  logic        io_data_err;

  modport master (
    output io_req, io_wr, io_wen, io_addr, io_wdata,
    input  io_req_ack, io_rdata, io_data_ack, io_data_err
  );
  modport slave (
    input  io_req, io_wr, io_wen, io_addr, io_wdata,
    output io_req_ack, io_rdata, io_data_ack, io_data_err
  );
`else
  modport master (
    output io_req, io_wr, io_wen, io_addr, io_wdata,
    input  io_req_ack, io_rdata, io_data_ack
  );
  modport slave (
    input  io_req, io_wr, io_wen, io_addr, io_wdata,
    output io_req_ack, io_rdata, io_data_ack
  );
`endif
endinterface

// File: rtl/io_mem_slave.sv
// io_mem_slave: spike IO bus target backed by a byte-addressed scratch memory.
// Split transaction: address phase (io_req/io_req_ack) with REQ_WAIT wait states,
// then a single-cycle io_data_ack pulse DATA_WAIT edges after the accept edge.
// Optional macro IO_SLAVE_ERR_EN: accesses with io_addr[31:28] != BASE_NIB are
// flagged on io_data_err, writes are discarded and reads return 32'hDEADBEEF.
// Without it the upper address bits are ignored and every address aliases.
// Wait counters are 8 bits wide, so REQ_WAIT must stay below 256.
module io_mem_slave #(
  parameter int          MEM_AW    = 8,
  parameter logic [3:0]  BASE_NIB  = 4'hF,
  parameter int          REQ_WAIT  = 0,
  parameter int          DATA_WAIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  io_mem_slave_if.slave  io
);

  localparam int            CW           = 8;
  localparam logic [CW-1:0] ONE          = CW'(1);
  localparam logic [CW-1:0] REQ_WAIT_C   = CW'(REQ_WAIT);
  localparam logic [CW-1:0] DATA_WAIT_M1 = CW'(DATA_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_AWAIT, S_DWAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                req_ack;
  logic                accept;

  // Transaction context captured at the accept edge.
  logic [MEM_AW-1:0]   addr_q;
  logic                wr_q;
  logic [3:0]          wen_q;
  logic [31:0]         wdata_q;
  logic                ok_q;
  logic [31:0]         rdata_q;

  // Context seen by the memory: live bus on the accept cycle, latched copy later.
  logic [MEM_AW-1:0]   c_addr;
  logic                c_wr;
  logic [3:0]          c_wen;
  logic [31:0]         c_wdata;
  logic                c_ok;
  logic                in_range;
  logic                commit_we;
  logic [MEM_AW-1:0]   lane_addr [4];
  logic [31:0]         rd_word;
  logic [31:0]         rd_value;

  logic [7:0]          mem [2**MEM_AW];

  // Only the low address bits index the array; the rest is a range tag at most.
  logic                unused_bits;
  assign unused_bits = ^{io.io_addr, BASE_NIB};

`ifdef IO_SLAVE_ERR_EN
  assign in_range = (io.io_addr[31:28] == BASE_NIB);
`else
  assign in_range = 1'b1;
`endif

  // Next-state, wait counter and address-phase acknowledge.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_ack = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (REQ_WAIT == 0) begin
          req_ack = io.io_req;
        end else if (io.io_req) begin
          state_d = S_AWAIT;
          cnt_d   = ONE;
        end
      end
      S_AWAIT: begin
        req_ack = io.io_req && (cnt_q == REQ_WAIT_C);
        if (!io.io_req) begin
          // Abandoned request: back to idle with no side effects.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q < REQ_WAIT_C) begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_DWAIT: begin
        if (cnt_q == DATA_WAIT_M1) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // The combinational ack must not follow io_req while the block is held in reset.
    req_ack = req_ack & rst_n;
    accept  = req_ack;
    if (accept) begin
      state_d = (DATA_WAIT == 1) ? S_RESP : S_DWAIT;
      cnt_d   = (DATA_WAIT == 1) ? '0 : ONE;
    end
  end

  // Select live bus or latched context and derive the per-lane byte addresses.
  always_comb begin
    c_addr  = accept ? io.io_addr[MEM_AW-1:0] : addr_q;
    c_wr    = accept ? io.io_wr               : wr_q;
    c_wen   = accept ? io.io_wen              : wen_q;
    c_wdata = accept ? io.io_wdata            : wdata_q;
    c_ok    = accept ? in_range               : ok_q;
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = c_addr + MEM_AW'(i);
    end
    rd_word = {mem[lane_addr[3]], mem[lane_addr[2]], mem[lane_addr[1]], mem[lane_addr[0]]};
`ifdef IO_SLAVE_ERR_EN
    rd_value = in_range ? rd_word : 32'hDEADBEEF;
`else
    rd_value = rd_word;
`endif
    // Writes land on the edge that enters RESP so a reset during DWAIT drops them.
    commit_we = (state_d == S_RESP) && c_wr && c_ok;
  end

  // State register and transaction context capture.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wen_q   <= '0;
      wdata_q <= '0;
      ok_q    <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= io.io_addr[MEM_AW-1:0];
        wr_q    <= io.io_wr;
        wen_q   <= io.io_wen;
        wdata_q <= io.io_wdata;
        ok_q    <= in_range;
        rdata_q <= rd_value;
      end
    end
  end

  // Byte-lane writes into the scratch array.
  // NOTE: the memory array is deliberately not reset; only control state is.
  always_ff @(posedge clk) begin
    if (commit_we) begin
      for (int i = 0; i < 4; i++) begin
        if (c_wen[i]) begin
          mem[lane_addr[i]] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

  assign io.io_req_ack  = req_ack;
  assign io.io_data_ack = (state_q == S_RESP);
  assign io.io_rdata    = ((state_q == S_RESP) && !wr_q) ? rdata_q : 32'h0;
`ifdef IO_SLAVE_ERR_EN
  assign io.io_data_err = (state_q == S_RESP) && !ok_q;
`endif

endmodule

// File: tb/tb_io_mem_slave.sv
// Directed self-checking bench for io_mem_slave: one instance with default wait
// states (u0) and one with REQ_WAIT=2, DATA_WAIT=3 (u1). Inputs change on the
// falling edge, outputs are sampled on the falling edge or 1 ns after a drive.
module tb_io_mem_slave;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  io_mem_slave_if b0 ();
  io_mem_slave_if b1 ();

  io_mem_slave u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (b0.slave)
  );

  io_mem_slave #(
    .REQ_WAIT  (2),
    .DATA_WAIT (3)
  ) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer on u0; entered and left on a falling edge in IDLE.
  task automatic xfer0(input string tag, input logic wr, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic [31:0] mask);
    b0.io_req = 1'b1; b0.io_wr = wr; b0.io_wen = wen;
    b0.io_addr = addr; b0.io_wdata = wdata;
    #1 check({tag, " req_ack same cycle"}, 32'(b0.io_req_ack), 32'd1);
    @(negedge clk);
    check({tag, " data_ack"}, 32'(b0.io_data_ack), 32'd1);
    check({tag, " req_ack in RESP"}, 32'(b0.io_req_ack), 32'd0);
    if (!wr) check({tag, " rdata"}, b0.io_rdata & mask, exp_rd);
`ifdef IO_SLAVE_ERR_EN
    check({tag, " data_err"}, 32'(b0.io_data_err), 32'(addr[31:28] != 4'hF));
`endif
    b0.io_req = 1'b0; b0.io_wr = 1'b0; b0.io_wen = 4'h0;
    b0.io_addr = 32'h0; b0.io_wdata = 32'h0;
    @(negedge clk);
    check({tag, " data_ack low after"}, 32'(b0.io_data_ack), 32'd0);
    check({tag, " rdata zero after"}, b0.io_rdata, 32'h0);
  endtask

  // One transfer on u1 (REQ_WAIT=2, DATA_WAIT=3); full-word writes.
  task automatic xfer1(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd);
    b1.io_req = 1'b1; b1.io_wr = wr; b1.io_wen = 4'hF;
    b1.io_addr = addr; b1.io_wdata = wdata;
    #1 check({tag, " ack wait0"}, 32'(b1.io_req_ack), 32'd0);
    @(negedge clk);
    check({tag, " ack wait1"}, 32'(b1.io_req_ack), 32'd0);
    @(negedge clk);
    check({tag, " ack after 2"}, 32'(b1.io_req_ack), 32'd1);
    @(negedge clk);
    check({tag, " ack in DWAIT"}, 32'(b1.io_req_ack), 32'd0);
    b1.io_req = 1'b0; b1.io_wr = 1'b0; b1.io_wdata = 32'h0; b1.io_addr = 32'h0;
    check({tag, " data_ack edge1"}, 32'(b1.io_data_ack), 32'd0);
    @(negedge clk);
    check({tag, " data_ack edge2"}, 32'(b1.io_data_ack), 32'd0);
    @(negedge clk);
    check({tag, " data_ack edge3"}, 32'(b1.io_data_ack), 32'd1);
    if (!wr) check({tag, " rdata"}, b1.io_rdata, exp_rd);
    @(negedge clk);
    check({tag, " data_ack low after"}, 32'(b1.io_data_ack), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    b0.io_req = 1'b0; b0.io_wr = 1'b0; b0.io_wen = 4'h0; b0.io_addr = 32'h0; b0.io_wdata = 32'h0;
    b1.io_req = 1'b0; b1.io_wr = 1'b0; b1.io_wen = 4'h0; b1.io_addr = 32'h0; b1.io_wdata = 32'h0;

    // Reset state.
    @(negedge clk);
    check("rst u0 data_ack", 32'(b0.io_data_ack), 32'd0);
    check("rst u0 rdata", b0.io_rdata, 32'h0);
    check("rst u1 data_ack", 32'(b1.io_data_ack), 32'd0);
    check("rst u1 req_ack", 32'(b1.io_req_ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default timing: full word, partial write, wrap-around, back-to-back.
    xfer0("wr_full",    1'b1, 4'hF,    32'hF000_0010, 32'h1122_3344, 32'h0, 32'h0);
    xfer0("rd_full",    1'b0, 4'hF,    32'hF000_0010, 32'h0, 32'h1122_3344, 32'hFFFF_FFFF);
    xfer0("wr_part",    1'b1, 4'b0001, 32'hF000_0011, 32'h0000_00AA, 32'h0, 32'h0);
    xfer0("rd_part",    1'b0, 4'hF,    32'hF000_0010, 32'h0, 32'h1122_AA44, 32'hFFFF_FFFF);
    xfer0("wr_wrap",    1'b1, 4'hF,    32'hF000_00FE, 32'hA1B2_C3D4, 32'h0, 32'h0);
    xfer0("rd_wrap_lo", 1'b0, 4'hF,    32'hF000_0000, 32'h0, 32'h0000_A1B2, 32'h0000_FFFF);
    xfer0("rd_wrap_fe", 1'b0, 4'h0,    32'hF000_00FE, 32'h0, 32'hA1B2_C3D4, 32'hFFFF_FFFF);
`ifdef IO_SLAVE_ERR_EN
    xfer0("err_wr",     1'b1, 4'hF,    32'h3000_0010, 32'h1234_5678, 32'h0, 32'h0);
    xfer0("err_keep",   1'b0, 4'hF,    32'hF000_0010, 32'h0, 32'h1122_AA44, 32'hFFFF_FFFF);
    xfer0("err_rd",     1'b0, 4'hF,    32'h3000_0010, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
`else
    xfer0("alias_rd",   1'b0, 4'hF,    32'h3000_00FE, 32'h0, 32'hA1B2_C3D4, 32'hFFFF_FFFF);
    xfer0("alias_wr",   1'b1, 4'hF,    32'h2000_0040, 32'h0102_0304, 32'h0, 32'h0);
    xfer0("alias_chk",  1'b0, 4'hF,    32'hF000_0040, 32'h0, 32'h0102_0304, 32'hFFFF_FFFF);
`endif

    // Wait states on u1.
    xfer1("w1_wr", 1'b1, 32'hF000_0020, 32'hCAFE_F00D, 32'h0);
    xfer1("w1_rd", 1'b0, 32'hF000_0020, 32'h0, 32'hCAFE_F00D);

    // Request abandoned after one cycle: no ack, no write, FSM back to IDLE.
    b1.io_req = 1'b1; b1.io_wr = 1'b1; b1.io_wen = 4'hF;
    b1.io_addr = 32'hF000_0020; b1.io_wdata = 32'h0;
    #1 check("abandon ack0", 32'(b1.io_req_ack), 32'd0);
    @(negedge clk);
    check("abandon ack1", 32'(b1.io_req_ack), 32'd0);
    b1.io_req = 1'b0; b1.io_wr = 1'b0;
    @(negedge clk);
    check("abandon data_ack", 32'(b1.io_data_ack), 32'd0);
    xfer1("abandon_rd", 1'b0, 32'hF000_0020, 32'h0, 32'hCAFE_F00D);

    // Reset in the middle of DWAIT aborts the pending write.
    b1.io_req = 1'b1; b1.io_wr = 1'b1; b1.io_wen = 4'hF;
    b1.io_addr = 32'hF000_0020; b1.io_wdata = 32'h5555_5555;
    @(negedge clk);
    @(negedge clk);
    check("rstmid accept", 32'(b1.io_req_ack), 32'd1);
    @(negedge clk);
    b1.io_req = 1'b0; b1.io_wr = 1'b0;
    b0.io_req = 1'b1; b0.io_addr = 32'hF000_0010;
    rst_n = 1'b0;
    #1;
    check("rstmid u1 data_ack", 32'(b1.io_data_ack), 32'd0);
    check("rstmid u1 rdata", b1.io_rdata, 32'h0);
    check("rstmid u1 req_ack", 32'(b1.io_req_ack), 32'd0);
    check("rstmid u0 req_ack", 32'(b0.io_req_ack), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rstmid no data_ack", 32'(b1.io_data_ack), 32'd0);
    b0.io_req = 1'b0; b0.io_addr = 32'h0;
    rst_n = 1'b1;
    @(negedge clk);
    xfer1("rstmid_rd", 1'b0, 32'hF000_0020, 32'h0, 32'hCAFE_F00D);
    xfer0("rst_mem_kept", 1'b0, 4'hF, 32'hF000_0010, 32'h0, 32'h1122_AA44, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
